// File: rtl/misc_outs_pulse_pkg.sv
// rtl/misc_outs_pulse_pkg.sv - register map and bus constants for the misc output port
package misc_outs_pulse_pkg;

    localparam int BUS_WIDTH  = 32;
    localparam int ADDR_WIDTH = 3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA       = 3'd0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_SET        = 3'd1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_CLR        = 3'd2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PULSE_MASK = 3'd3;
    localparam logic [ADDR_WIDTH-1:0] ADDR_PULSE_LEN  = 3'd4;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS     = 3'd5;

endpackage

// File: rtl/misc_outs_pulse_if.sv
// rtl/misc_outs_pulse_if.sv - Avalon-MM slave bus bundle for the misc output port
interface misc_outs_pulse_if;
    import misc_outs_pulse_pkg::*;

    logic [ADDR_WIDTH-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic                  read_n;
    logic [BUS_WIDTH-1:0]  writedata;
    logic [BUS_WIDTH-1:0]  readdata;
    logic                  readdatavalid;

    modport master (
        output address, chipselect, write_n, read_n, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, chipselect, write_n, read_n, writedata,
        output readdata, readdatavalid
    );

endinterface

// File: rtl/misc_outs_pulse_timer.sv
// rtl/misc_outs_pulse_timer.sv - one output bit's one-shot down-counter
module misc_outs_pulse_timer #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 kill,
    input  logic [CNT_WIDTH-1:0] len,
    output logic                 active,
    output logic                 expire
);

    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] len_eff;

    assign len_eff = (len == '0) ? CNT_WIDTH'(1) : len;
    assign active  = (cnt != '0);
    // A retrigger or kill on the final count suppresses the expiry.
    assign expire  = (cnt == CNT_WIDTH'(1)) & ~load & ~kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len_eff;
        end else if (kill) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt - CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/misc_outs_pulse.sv
// rtl/misc_outs_pulse.sv - misc board output port with set/clear access and per-bit one-shot pulses
module misc_outs_pulse
    import misc_outs_pulse_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    misc_outs_pulse_if.slave      bus,
    output logic [DATA_WIDTH-1:0] out_port
);

    logic                  wr;
    logic                  rd;
    logic                  wr_data;
    logic                  wr_trig;
    logic                  wr_mask;
    logic                  wr_len;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] nd;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] data_next;
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic [CNT_WIDTH-1:0]  pulse_len;
    logic [DATA_WIDTH-1:0] load;
    logic [DATA_WIDTH-1:0] kill;
    logic [DATA_WIDTH-1:0] expire;
    logic [DATA_WIDTH-1:0] active;
    logic [BUS_WIDTH-1:0]  rd_mux;
    logic [BUS_WIDTH-1:0]  readdata_q;
    logic                  readdatavalid_q;

    // A simultaneous read and write is treated as a write only.
    assign wr = bus.chipselect & ~bus.write_n;
    assign rd = bus.chipselect & ~bus.read_n & bus.write_n;
    assign wd = bus.writedata[DATA_WIDTH-1:0];

    always_comb begin
        nd      = data;
        wr_data = 1'b0;
        wr_trig = 1'b0;
        if (wr) begin
            case (bus.address)
                ADDR_DATA: begin
                    nd      = wd;
                    wr_data = 1'b1;
                    wr_trig = 1'b1;
                end
                ADDR_SET: begin
                    nd      = data | wd;
                    wr_data = 1'b1;
                    wr_trig = 1'b1;
                end
                ADDR_CLR: begin
                    nd      = data & ~wd;
                    wr_data = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_mask = wr & (bus.address == ADDR_PULSE_MASK);
    assign wr_len  = wr & (bus.address == ADDR_PULSE_LEN);

    assign load = {DATA_WIDTH{wr_trig}} & pulse_mask & nd;
    assign kill = ({DATA_WIDTH{wr_data}} & ~nd) | ({DATA_WIDTH{wr_mask}} & ~wd);

    // Retrigger forces the bit high; otherwise an expiring pulse clears it.
    assign data_next = load | (~expire & (wr_data ? nd : data));

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_timer
        misc_outs_pulse_timer #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_timer (
            .clk    (clk),
            .reset  (reset),
            .load   (load[i]),
            .kill   (kill[i]),
            .len    (pulse_len),
            .active (active[i]),
            .expire (expire[i])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:       rd_mux[DATA_WIDTH-1:0] = data;
            ADDR_PULSE_MASK: rd_mux[DATA_WIDTH-1:0] = pulse_mask;
            ADDR_PULSE_LEN:  rd_mux[CNT_WIDTH-1:0]  = pulse_len;
            ADDR_STATUS:     rd_mux[DATA_WIDTH-1:0] = active;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data            <= RESET_VALUE;
            pulse_mask      <= '0;
            pulse_len       <= CNT_WIDTH'(1);
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            data            <= data_next;
            readdatavalid_q <= rd;
            if (wr_mask) begin
                pulse_mask <= wd;
            end
            if (wr_len) begin
                pulse_len <= bus.writedata[CNT_WIDTH-1:0];
            end
            if (rd) begin
                readdata_q <= rd_mux;
            end
        end
    end

    assign bus.readdata      = readdata_q;
    assign bus.readdatavalid = readdatavalid_q;
    assign out_port          = data;

endmodule

// File: tb/tb_misc_outs_pulse.sv
// tb/tb_misc_outs_pulse.sv - self-checking bench for misc_outs_pulse
module tb_misc_outs_pulse;
    import misc_outs_pulse_pkg::*;

    localparam int        DW = 8;
    localparam int        CW = 16;
    localparam logic [7:0] RV = 8'h00;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] out_port;

    misc_outs_pulse_if bus();

    misc_outs_pulse #(
        .DATA_WIDTH  (DW),
        .CNT_WIDTH   (CW),
        .RESET_VALUE (RV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Reference model: each pulsing bit remembers the absolute edge number at which it falls.
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_mask;
    logic [CW-1:0] m_len;
    longint        m_end [DW];
    longint        now = 0;
    logic          m_rdv;
    logic [31:0]   m_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_data  = RV;
        m_mask  = '0;
        m_len   = 16'd1;
        m_rdv   = 1'b0;
        m_rdata = '0;
        for (int i = 0; i < DW; i++) m_end[i] = 0;
    endtask

    task automatic model_edge(input logic [2:0] a, input logic w, input logic r, input logic [31:0] wd);
        longint        e;
        longint        plen;
        logic [31:0]   rv;
        logic [DW-1:0] nd;
        logic [DW-1:0] st;
        logic          expiring;
        e = now + 1;
        for (int i = 0; i < DW; i++) st[i] = (m_end[i] > now);
        rv = 0;
        case (a)
            3'd0: rv = 32'(m_data);
            3'd3: rv = 32'(m_mask);
            3'd4: rv = 32'(m_len);
            3'd5: rv = 32'(st);
            default: rv = 0;
        endcase
        m_rdv = r && !w;
        if (m_rdv) m_rdata = rv;
        plen = (m_len == 0) ? 1 : longint'(m_len);
        case (a)
            3'd0: nd = wd[DW-1:0];
            3'd1: nd = m_data | wd[DW-1:0];
            default: nd = m_data & ~wd[DW-1:0];
        endcase
        for (int i = 0; i < DW; i++) begin
            expiring = (m_end[i] == e);
            if (w && a <= 3'd2) begin
                if (nd[i] && m_mask[i] && a <= 3'd1) begin
                    m_data[i] = 1'b1;
                    m_end[i]  = e + plen;
                end else if (!nd[i] || expiring) begin
                    m_data[i] = 1'b0;
                    m_end[i]  = 0;
                end else begin
                    m_data[i] = 1'b1;
                end
            end else if (w && a == 3'd3 && !wd[i]) begin
                m_end[i] = 0;
            end else if (expiring) begin
                m_data[i] = 1'b0;
                m_end[i]  = 0;
            end
        end
        if (w && a == 3'd3) m_mask = wd[DW-1:0];
        if (w && a == 3'd4) m_len  = wd[CW-1:0];
        now = e;
    endtask

    task automatic step(input logic [2:0] a, input logic cs, input logic w, input logic r, input logic [31:0] wd);
        @(negedge clk);
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = ~w;
        bus.read_n     = ~r;
        bus.writedata  = wd;
        @(posedge clk);
        model_edge(a, cs & w, cs & r, wd);
        #1;
        chk("out_port", 32'(out_port), 32'(m_data));
        chk("readdatavalid", 32'(bus.readdatavalid), 32'(m_rdv));
        if (m_rdv) chk("readdata", bus.readdata, m_rdata);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(a, 1'b1, 1'b1, 1'b0, wd);
    endtask

    task automatic rdreg(input logic [2:0] a);
        step(a, 1'b1, 1'b0, 1'b1, 32'h0);
    endtask

    task automatic idle();
        step(3'd0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int hi;
        int lows;
        logic [2:0] a;

        reset          = 1'b1;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.read_n     = 1'b1;
        bus.writedata  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_port", 32'(out_port), 32'(RV));
        chk("rst_readdatavalid", 32'(bus.readdatavalid), 0);
        chk("rst_readdata", bus.readdata, 0);
        @(negedge clk) reset = 1'b0;

        rdreg(ADDR_DATA);
        chk("rd_data_reset", bus.readdata, 32'h00);
        rdreg(ADDR_STATUS);
        chk("rd_status_reset", bus.readdata, 32'h00);
        rdreg(ADDR_PULSE_LEN);
        chk("rd_len_reset", bus.readdata, 32'h01);

        wr(ADDR_DATA, 32'hA5);
        chk("data_write", 32'(out_port), 32'hA5);
        wr(ADDR_SET, 32'h0A);
        chk("set_write", 32'(out_port), 32'hAF);
        wr(ADDR_CLR, 32'h21);
        chk("clr_write", 32'(out_port), 32'h8E);

        wr(ADDR_CLR, 32'hFF);
        wr(ADDR_PULSE_MASK, 32'h01);
        wr(ADDR_PULSE_LEN, 32'd5);
        wr(ADDR_SET, 32'h01);
        hi = int'(out_port[0]);
        repeat (8) begin
            rdreg(ADDR_STATUS);
            hi += int'(out_port[0]);
        end
        chk("pulse_len5_cycles", hi, 5);

        // Retrigger mid-pulse, then again exactly on the expiry edge.
        lows = 0;
        wr(ADDR_SET, 32'h01);
        repeat (2) begin idle(); lows += int'(!out_port[0]); end
        wr(ADDR_SET, 32'h01);
        repeat (4) begin idle(); lows += int'(!out_port[0]); end
        wr(ADDR_SET, 32'h01);
        chk("retrig_no_gap", lows, 0);
        hi = int'(out_port[0]);
        repeat (8) begin
            idle();
            hi += int'(out_port[0]);
        end
        chk("retrig_tail_cycles", hi, 5);

        wr(ADDR_PULSE_LEN, 32'd0);
        wr(ADDR_SET, 32'h01);
        hi = int'(out_port[0]);
        repeat (3) begin
            idle();
            hi += int'(out_port[0]);
        end
        chk("len0_one_cycle", hi, 1);

        wr(ADDR_PULSE_LEN, 32'd100);
        wr(ADDR_SET, 32'h01);
        repeat (3) idle();
        wr(ADDR_CLR, 32'h01);
        chk("clr_mid_pulse", 32'(out_port[0]), 0);
        rdreg(ADDR_STATUS);
        chk("status_after_clr", 32'(bus.readdata[0]), 0);

        wr(ADDR_PULSE_LEN, 32'd10);
        wr(ADDR_SET, 32'h01);
        idle();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out", 32'(out_port), 32'(RV));
        model_reset();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        hi = 0;
        repeat (12) begin
            idle();
            hi += int'(out_port[0]);
        end
        chk("no_resume_after_reset", hi, 0);

        for (int n = 0; n < 400; n++) begin
            a = 3'($urandom_range(0, 7));
            step(a, ($urandom_range(0, 3) != 0), 1'($urandom),
                 1'($urandom), (a == 3'd4) ? 32'($urandom_range(0, 6)) : $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
